// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges 32-bit execute-stage load/store requests onto a 16-bit
// asynchronous SRAM as two halfword accesses (LO then HI), holding the
// pipeline via ready until the word transfer is complete.
module sram_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = 17;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [CNT_W-1:0] wait_cnt;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;
   logic             op_wr_q;

   logic [31:0]      offset;
   logic             unused_offset;
   logic             req;
   logic             last_cyc;

   logic [IDX_W-1:0] idx_src;
   logic [31:0]      wdata_src;
   logic             wr_src;
   logic [17:0]      sram_addr_nx;
   logic [15:0]      dq_out_nx;
   logic             drive_nx;

   // Byte offset into the SRAM window; only the word index bits are used.
   assign offset        = address - BASE_ADDR;
   assign unused_offset = ^{offset[31:19], offset[1:0]};
   assign req           = rd_en | wr_en;
   assign last_cyc      = (wait_cnt == LAST_CNT);

   // Pipeline may advance only when idle with nothing asked, or on completion.
   assign ready = (state == DONE) || ((state == IDLE) && !req);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: each halfword phase is held for WAIT_CYCLES cycles.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (req)      state_nx = LO;
         LO:   if (last_cyc) state_nx = HI;
         HI:   if (last_cyc) state_nx = DONE;
         DONE:               state_nx = IDLE;
         default:            state_nx = IDLE;
      endcase
   end

   // Wait counter: restarts on every state entry, counts within LO/HI.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state_nx != state) begin
         wait_cnt <= '0;
      end else if ((state == LO) || (state == HI)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Request capture; later input changes are ignored until back in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         wdata_q <= '0;
         op_wr_q <= 1'b0;
      end else if ((state == IDLE) && req) begin
         idx_q   <= offset[18:2];
         wdata_q <= write_data;
         op_wr_q <= wr_en;
      end
   end

   // SRAM pin values for the coming cycle, so the pins register in step with state.
   always_comb begin
      idx_src      = (state == IDLE) ? offset[18:2] : idx_q;
      wdata_src    = (state == IDLE) ? write_data   : wdata_q;
      wr_src       = (state == IDLE) ? wr_en        : op_wr_q;
      sram_addr_nx = '0;
      dq_out_nx    = '0;
      drive_nx     = 1'b0;
      if (state_nx == LO) begin
         sram_addr_nx = {idx_src, 1'b0};
         if (wr_src) begin
            drive_nx  = 1'b1;
            dq_out_nx = wdata_src[15:0];
         end
      end else if (state_nx == HI) begin
         sram_addr_nx = {idx_src, 1'b1};
         if (wr_src) begin
            drive_nx  = 1'b1;
            dq_out_nx = wdata_src[31:16];
         end
      end
   end

   // Registered SRAM pins; reset drops any strobe at the very next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         sram_addr   <= sram_addr_nx;
         sram_dq_out <= dq_out_nx;
         sram_dq_oe  <= drive_nx;
         sram_we_n   <= !drive_nx;
      end
   end

   // Load result: each half sampled on the final cycle of its phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data <= '0;
      end else if (!op_wr_q && last_cyc) begin
         if (state == LO) begin
            read_data[15:0] <= sram_dq_in;
         end else if (state == HI) begin
            read_data[31:16] <= sram_dq_in;
         end
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural SRAM that commits a
// write only after the strobe has been held WAIT_CYCLES cycles on one address.
module tb_sram_ctrl;

   localparam int unsigned W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   logic        rd1, wr1;
   logic [31:0] rdata1;
   logic        ready1, swe1;
   logic [17:0] unused_addr1;
   logic [15:0] unused_dq1;
   logic        unused_oe1;

   logic [15:0] mem [0:63];
   logic        init_mem;
   int          hold_cnt;
   logic [17:0] hold_addr;

   int vectors = 0;
   int miscompares = 0;

   logic [17:0] tr_addr [0:19];
   logic [15:0] tr_dq   [0:19];
   logic        tr_oe   [0:19];

   always #5 clk = ~clk;

   sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1),
      .address(address), .write_data(write_data), .read_data(rdata1),
      .ready(ready1), .sram_addr(unused_addr1), .sram_dq_out(unused_dq1),
      .sram_dq_in(16'h5A5A), .sram_dq_oe(unused_oe1), .sram_we_n(swe1)
   );

   assign sram_dq_in = mem[sram_addr[5:0]];

   // Behavioural SRAM: a halfword lands only once held for W cycles.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
         hold_cnt <= 0;
      end else if (!sram_we_n) begin
         if (hold_cnt != 0 && sram_addr == hold_addr) begin
            hold_cnt <= hold_cnt + 1;
            if (hold_cnt + 1 == int'(W)) mem[sram_addr[5:0]] <= sram_dq_out;
         end else begin
            hold_cnt <= 1;
         end
         hold_addr <= sram_addr;
      end else begin
         hold_cnt <= 0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request; returns at the first cycle ready is high (DONE).
   task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, output int low, output int wel);
      wr_en = w; rd_en = r; address = a; write_data = d;
      low = 0; wel = 0;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (ready) break;
         tr_addr[low] = sram_addr; tr_dq[low] = sram_dq_out; tr_oe[low] = sram_dq_oe;
         low++;
         if (!sram_we_n) wel++;
         tick;
         wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_FFFC;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", read_data); end
      vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
      vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b want 0", sram_dq_oe); end
      vectors++; if (sram_addr !== 18'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", sram_addr); end
      init_mem = 1'b0;
      rst = 1'b0;
      tick;
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready); end
   endtask

   task automatic test_write;
      int low, wel;
      logic [17:0] ea;
      logic [15:0] ed;
      do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, low, wel);
      vectors++; if (low !== 5) begin miscompares++; $display("FAIL wr_ready_low got %0d want 5", low); end
      vectors++; if (wel !== 4) begin miscompares++; $display("FAIL wr_we_low got %0d want 4", wel); end
      vectors++; if (mem[2] !== 16'hBEEF) begin miscompares++; $display("FAIL wr_mem2 got %h want beef", mem[2]); end
      vectors++; if (mem[3] !== 16'hDEAD) begin miscompares++; $display("FAIL wr_mem3 got %h want dead", mem[3]); end
      vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL wr_rdata got %h want 0", read_data); end
      if (low == 5) begin
         for (int i = 1; i < 5; i++) begin
            ea = (i < 3) ? 18'd2 : 18'd3;
            ed = (i < 3) ? 16'hBEEF : 16'hDEAD;
            vectors++; if (tr_addr[i] !== ea || tr_dq[i] !== ed || tr_oe[i] !== 1'b1) begin
               miscompares++; $display("FAIL wr_pins[%0d] got %h/%h/%b want %h/%h/1", i, tr_addr[i], tr_dq[i], tr_oe[i], ea, ed);
            end
         end
      end
      tick;
   endtask

   task automatic test_read;
      int low, wel;
      do_access(1'b0, 1'b1, 32'd1028, 32'h0, low, wel);
      vectors++; if (low !== 5) begin miscompares++; $display("FAIL rd_ready_low got %0d want 5", low); end
      vectors++; if (wel !== 0) begin miscompares++; $display("FAIL rd_we_low got %0d want 0", wel); end
      vectors++; if (read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", read_data); end
      vectors++; if (low == 5 && (tr_oe[1] | tr_oe[2] | tr_oe[3] | tr_oe[4]) !== 1'b0) begin
         miscompares++; $display("FAIL rd_oe got 1 want 0");
      end
      tick;
      vectors++; if (read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_hold got %h want deadbeef", read_data); end
   endtask

   task automatic test_both;
      int low, wel;
      do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, low, wel);
      vectors++; if (wel !== 4) begin miscompares++; $display("FAIL both_we_low got %0d want 4", wel); end
      vectors++; if (mem[0] !== 16'h5678) begin miscompares++; $display("FAIL both_mem0 got %h want 5678", mem[0]); end
      vectors++; if (mem[1] !== 16'h1234) begin miscompares++; $display("FAIL both_mem1 got %h want 1234", mem[1]); end
      vectors++; if (read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL both_rdata got %h want deadbeef", read_data); end
      tick;
   endtask

   task automatic test_reset_abort;
      wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
      tick;
      wr_en = 1'b0;
      tick; tick;
      vectors++; if (sram_addr !== 18'd5 || sram_we_n !== 1'b0) begin
         miscompares++; $display("FAIL abort_hi got %h/%b want 5/0", sram_addr, sram_we_n);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      vectors++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
         miscompares++; $display("FAIL abort_strobe got %b/%b want 1/0", sram_we_n, sram_dq_oe);
      end
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got %b want 1", ready); end
      vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL abort_rdata got %h want 0", read_data); end
      vectors++; if (mem[4] !== 16'hF00D) begin miscompares++; $display("FAIL abort_mem4 got %h want f00d", mem[4]); end
      vectors++; if (mem[5] !== 16'h1005) begin miscompares++; $display("FAIL abort_mem5 got %h want 1005", mem[5]); end
      tick;
      vectors++; if (sram_we_n !== 1'b1 || ready !== 1'b1) begin
         miscompares++; $display("FAIL abort_replay got %b/%b want 1/1", sram_we_n, ready);
      end
   endtask

   task automatic test_back_to_back;
      int low, wel;
      do_access(1'b0, 1'b1, 32'd1024, 32'h0, low, wel);
      vectors++; if (low !== 5) begin miscompares++; $display("FAIL b2b_first_low got %0d want 5", low); end
      vectors++; if (read_data !== 32'h12345678) begin miscompares++; $display("FAIL b2b_first got %h want 12345678", read_data); end
      tick;
      do_access(1'b0, 1'b1, 32'd1028, 32'h0, low, wel);
      vectors++; if (low !== 5) begin miscompares++; $display("FAIL b2b_second_low got %0d want 5", low); end
      vectors++; if (read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL b2b_second got %h want deadbeef", read_data); end
      tick;
   endtask

   task automatic test_wait1;
      int low, wel;
      for (int k = 0; k < 2; k++) begin
         wr1 = (k == 0); rd1 = (k == 1); address = 32'd1024; write_data = 32'h0BADCAFE;
         low = 0; wel = 0;
         #1;
         for (int i = 0; i < 20; i++) begin
            if (ready1) break;
            low++;
            if (!swe1) wel++;
            tick;
            wr1 = 1'b0; rd1 = 1'b0;
         end
         vectors++; if (low !== 3) begin miscompares++; $display("FAIL w1_ready_low[%0d] got %0d want 3", k, low); end
         vectors++; if (wel !== ((k == 0) ? 2 : 0)) begin miscompares++; $display("FAIL w1_we_low[%0d] got %0d want %0d", k, wel, (k == 0) ? 2 : 0); end
         tick;
      end
      vectors++; if (rdata1 !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL w1_rdata got %h want 5a5a5a5a", rdata1); end
   endtask

   initial begin
      rst = 1'b1; init_mem = 1'b1;
      rd_en = 1'b0; wr_en = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
      address = 32'h0; write_data = 32'h0;
      test_reset();
      test_write();
      test_read();
      test_both();
      test_reset_abort();
      test_back_to_back();
      test_wait1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
